// File: rtl/bl_wl_config_programmer.sv
// Streams narrow bitstream words into a full bitline frame per wordline row,
// then strobes that row's wordline with setup and hold margins around the pulse.
module bl_wl_config_programmer #(
    parameter int BL_WIDTH     = 315,
    parameter int WL_WIDTH     = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int WL_PULSE     = 2,
    localparam int ROW_W       = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1
) (
    input  logic                  prog_clk,
    input  logic                  prog_rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [BL_WIDTH-1:0]   bl_out,
    output logic [WL_WIDTH-1:0]   wl_out,
    output logic [ROW_W-1:0]      row_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int NW      = (BL_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int WORD_W  = (NW > 1) ? $clog2(NW) : 1;
    localparam int MAX_CNT = (SETUP_CYCLES > WL_PULSE) ? SETUP_CYCLES : WL_PULSE;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [WORD_W-1:0]   word_r, word_s;
    logic [ROW_W-1:0]    row_r, row_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [BL_WIDTH-1:0] bl_r, bl_s;
    logic [WL_WIDTH-1:0] wl_r, wl_s;
    logic                ready_r, busy_r, done_r;
    logic                xfer_s;

    // Next-state, frame assembly and wordline decode; the handshake uses the
    // registered ready so a transfer is exactly what the loader observes.
    always_comb begin
        state_s = state_r;
        word_s  = word_r;
        row_s   = row_r;
        cnt_s   = cnt_r;
        bl_s    = bl_r;
        wl_s    = '0;
        xfer_s  = cfg_valid && ready_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_LOAD;
                    row_s   = '0;
                    word_s  = '0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                if (xfer_s) begin
                    // Bits beyond BL_WIDTH in the last word simply have no target.
                    for (int i = 0; i < BL_WIDTH; i++) begin
                        if ((i / DATA_WIDTH) == int'(word_r)) begin
                            bl_s[i] = cfg_data[i % DATA_WIDTH];
                        end else begin
                            bl_s[i] = bl_r[i];
                        end
                    end
                    if (word_r == WORD_W'(NW - 1)) begin
                        state_s = ST_SETUP;
                        cnt_s   = '0;
                    end else begin
                        word_s = word_r + WORD_W'(1);
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_SETUP: begin
                if (cnt_r == CNT_W'(SETUP_CYCLES - 1)) begin
                    state_s = ST_PULSE;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_r == CNT_W'(WL_PULSE - 1)) begin
                    state_s = ST_HOLD;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (row_r == ROW_W'(WL_WIDTH - 1)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_LOAD;
                    row_s   = row_r + ROW_W'(1);
                    word_s  = '0;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (state_s == ST_PULSE) begin
            for (int i = 0; i < WL_WIDTH; i++) begin
                wl_s[i] = (int'(row_s) == i);
            end
        end else begin
            wl_s = '0;
        end
    end

    // State, counters and all outputs are registered from the next-state decode.
    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            state_r <= ST_IDLE;
            word_r  <= '0;
            row_r   <= '0;
            cnt_r   <= '0;
            bl_r    <= '0;
            wl_r    <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            word_r  <= word_s;
            row_r   <= row_s;
            cnt_r   <= cnt_s;
            bl_r    <= bl_s;
            wl_r    <= wl_s;
            ready_r <= (state_s == ST_LOAD);
            busy_r  <= (state_s inside {ST_LOAD, ST_SETUP, ST_PULSE, ST_HOLD});
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign cfg_ready = ready_r;
    assign bl_out    = bl_r;
    assign wl_out    = wl_r;
    assign row_idx   = row_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_bl_wl_config_programmer.sv
// Self-checking bench: directed scenarios plus randomized sessions, checked
// cycle by cycle against a timeline reference model of the programmer.
module tb_bl_wl_config_programmer;

    localparam int BL  = 10;
    localparam int DW  = 4;
    localparam int WLN = 2;
    localparam int SU  = 1;
    localparam int PW  = 2;
    localparam int NW  = (BL + DW - 1) / DW;
    localparam int RW  = (WLN > 1) ? $clog2(WLN) : 1;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;

    logic          prog_clk;
    logic          prog_rst_n;
    logic          start;
    logic [DW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [BL-1:0] bl_out;
    logic [WLN-1:0] wl_out;
    logic [RW-1:0] row_idx;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    bl_wl_config_programmer #(
        .BL_WIDTH(BL), .WL_WIDTH(WLN), .DATA_WIDTH(DW),
        .SETUP_CYCLES(SU), .WL_PULSE(PW)
    ) dut (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .bl_out(bl_out), .wl_out(wl_out), .row_idx(row_idx),
        .busy(busy), .done(done)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: session phase, row, word, cycles since the row's last word.
    int             m_mode  = M_IDLE;
    int             m_row   = 0;
    int             m_word  = 0;
    int             m_since = 0;
    logic [BL-1:0]  m_frame = '0;
    logic [BL-1:0]  prev_bl = '0;
    logic [WLN-1:0] prev_wl = '0;
    logic [WLN-1:0] exp_wl;
    logic           prev_done = 1'b0;
    int             pulses = 0;
    logic [BL-1:0]  pulse_bl[$];
    logic [WLN-1:0] pulse_wl[$];

    // Per-cycle comparison against the model, then advance the model by the inputs.
    always @(negedge prog_clk) begin
        exp_wl = '0;
        if (m_mode == M_RUN && m_since > SU && m_since <= SU + PW) exp_wl[m_row] = 1'b1;
        chk("busy", busy, (m_mode == M_LOAD || m_mode == M_RUN));
        chk("done", done, (m_mode == M_DONE));
        chk("ready", cfg_ready, (m_mode == M_LOAD));
        chk("wl", wl_out, exp_wl);
        chk("bl", bl_out, m_frame);
        chk("row_idx", row_idx, m_row);
        chk("wl_onehot0", $onehot0(wl_out), 1);
        if (wl_out != '0) chk("bl_stable", bl_out, prev_bl);
        if (wl_out != '0 && prev_wl == '0) begin
            pulses++;
            pulse_bl.push_back(bl_out);
            pulse_wl.push_back(wl_out);
        end
        if (done && !prev_done) chk("pulse_count", pulses, WLN);
        prev_bl   = bl_out;
        prev_wl   = wl_out;
        prev_done = done;

        if (!prog_rst_n) begin
            m_mode = M_IDLE; m_row = 0; m_word = 0; m_frame = '0;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: if (start) begin
                    m_mode = M_LOAD; m_row = 0; m_word = 0; pulses = 0;
                end
                M_LOAD: if (cfg_valid) begin
                    for (int j = 0; j < DW; j++)
                        if (m_word * DW + j < BL) m_frame[m_word * DW + j] = cfg_data[j];
                    m_word++;
                    if (m_word == NW) begin m_mode = M_RUN; m_since = 1; end
                end
                default: begin
                    if (m_since == SU + PW + 1) begin
                        if (m_row == WLN - 1) m_mode = M_DONE;
                        else begin m_row++; m_word = 0; m_mode = M_LOAD; end
                    end else m_since++;
                end
            endcase
        end
    end

    task automatic sync();
        @(posedge prog_clk); #1;
    endtask

    task automatic idle(input int n);
        cfg_valid = 1'b0;
        repeat (n) begin cfg_data = DW'($urandom); sync(); end
    endtask

    task automatic begin_session();
        pulse_bl.delete(); pulse_wl.delete();
        start = 1'b1; sync(); start = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d, input bit rnd_start);
        int n;
        n = 0;
        cfg_data = d; cfg_valid = 1'b1;
        start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge prog_clk);
        while (!cfg_ready && n < 100) begin n++; @(negedge prog_clk); end
        if (n >= 100) chk("push_timeout", 0, 1);
        sync();
        cfg_valid = 1'b0; start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin n++; @(negedge prog_clk); end
        chk("done_wait", done, 1);
        sync();
    endtask

    task automatic chk_frames(input string tag, input logic [BL-1:0] f0, input logic [BL-1:0] f1);
        chk({tag, "_npulse"}, pulse_bl.size(), WLN);
        if (pulse_bl.size() == WLN) begin
            chk({tag, "_bl0"}, pulse_bl[0], f0);
            chk({tag, "_wl0"}, pulse_wl[0], 2'b01);
            chk({tag, "_bl1"}, pulse_bl[1], f1);
            chk({tag, "_wl1"}, pulse_wl[1], 2'b10);
        end
    endtask

    logic [DW-1:0] words[WLN][NW];
    logic [BL-1:0] exp_fr[WLN];
    int            n_lat;

    initial begin
        prog_rst_n = 1'b0; start = 1'b0; cfg_data = '0; cfg_valid = 1'b0;
        repeat (3) @(posedge prog_clk);
        #1 prog_rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_bl", bl_out, 0);
        // valid while idle must not be consumed
        cfg_valid = 1'b1; cfg_data = 4'h9; repeat (3) sync(); cfg_valid = 1'b0;

        // basic two-row session
        begin_session();
        push(4'hA, 1'b0); push(4'h5, 1'b0); push(4'hF, 1'b0);
        push(4'h3, 1'b0); push(4'hC, 1'b0); push(4'h1, 1'b0);
        wait_done();
        chk_frames("t1", 10'b11_0101_1010, 10'b01_1100_0011);
        chk("t1_busy", busy, 0);

        // valid gap between words 1 and 2
        begin_session();
        push(4'hA, 1'b0); push(4'h5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("t2_gap_ready", cfg_ready, 1);
        end
        push(4'hF, 1'b0);
        n_lat = 0;
        while (wl_out == '0 && n_lat < 20) begin n_lat++; @(negedge prog_clk); end
        chk("t2_latency", n_lat, SU + 1);
        sync();
        push(4'h3, 1'b0); push(4'hC, 1'b0); push(4'h1, 1'b0);
        wait_done();
        chk_frames("t2", 10'b11_0101_1010, 10'b01_1100_0011);

        // reset during the row-0 pulse
        begin_session();
        push(4'h6, 1'b0); push(4'h7, 1'b0); push(4'h2, 1'b0);
        n_lat = 0;
        while (wl_out == '0 && n_lat < 20) begin n_lat++; @(negedge prog_clk); end
        chk("t3_in_pulse", wl_out, 2'b01);
        sync();
        prog_rst_n = 1'b0; sync(); prog_rst_n = 1'b1;
        @(negedge prog_clk);
        chk("t3_wl", wl_out, 0);
        chk("t3_bl", bl_out, 0);
        chk("t3_busy", busy, 0);
        sync();
        begin_session();
        push(4'hA, 1'b0); push(4'h5, 1'b0); push(4'hF, 1'b0);
        push(4'h3, 1'b0); push(4'hC, 1'b0); push(4'h1, 1'b0);
        wait_done();
        chk_frames("t3", 10'b11_0101_1010, 10'b01_1100_0011);

        // start during LOAD of row 1 is ignored; also restarts from DONE
        begin_session();
        @(negedge prog_clk);
        chk("t5_done_clr", done, 0);
        sync();
        push(4'h1, 1'b0); push(4'h2, 1'b0); push(4'h3, 1'b0);
        n_lat = 0;
        while (!(cfg_ready && row_idx == 1'b1) && n_lat < 20) begin n_lat++; @(negedge prog_clk); end
        sync();
        start = 1'b1; sync(); start = 1'b0;
        @(negedge prog_clk);
        chk("t4_row", row_idx, 1);
        chk("t4_busy", busy, 1);
        sync();
        push(4'h8, 1'b0); push(4'h4, 1'b0); push(4'h2, 1'b0);
        wait_done();
        chk_frames("t4", 10'b11_0010_0001, 10'b10_0100_1000);

        // randomized sessions with gaps and stray starts while busy
        for (int s = 0; s < 20; s++) begin
            for (int r = 0; r < WLN; r++)
                for (int k = 0; k < NW; k++) words[r][k] = DW'($urandom);
            for (int r = 0; r < WLN; r++)
                for (int b = 0; b < BL; b++) exp_fr[r][b] = words[r][b / DW][b % DW];
            begin_session();
            for (int r = 0; r < WLN; r++)
                for (int k = 0; k < NW; k++) begin
                    idle($urandom_range(0, 2));
                    push(words[r][k], 1'b1);
                end
            wait_done();
            chk_frames("rnd", exp_fr[0], exp_fr[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
